// File: rtl/aes_pkg.sv
// aes_pkg: AES word/block widths, S-box table, xtime and key-schedule FSM state type
package aes_pkg;
  localparam int AES_WORD = 32;
  localparam int AES_BLOCK = 128;
  typedef enum logic [1:0] {IDLE, GEN, HOLD, FIN} ks_state_t;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES S-box byte substitution, a in, q = S(a) out
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] q
);
  assign q = SBOX[{~a, 3'b111} -: 8];
endmodule

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128/192/256 key expansion (clk, rst, start, key_in in; busy, rk_valid/rk_ready/rk_index/rk_data stream, done); AES_KS_CACHE_EN adds cache_valid, rd_idx, rd_data round-key cache
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KEY_BITS-1:0]  key_in,
  output logic                 busy,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [3:0]           rk_index,
  output logic [AES_BLOCK-1:0] rk_data,
  output logic                 done
`ifdef AES_KS_CACHE_EN
  ,
  output logic                 cache_valid,
  input  logic [3:0]           rd_idx,
  output logic [AES_BLOCK-1:0] rd_data
`endif
);
  localparam int NK = KEY_BITS / AES_WORD;
  localparam int NR = NK + 6;
  localparam logic [5:0] NKW = 6'(NK);
  localparam logic [2:0] NKJ = 3'(NK - 1);
  localparam logic [5:0] LAST = 6'(4 * NR + 3);
  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
  end
  ks_state_t state, nxt;
  logic [KEY_BITS-1:0] win;
  logic [95:0] part;
  logic [5:0] i;
  logic [2:0] j;
  logic [7:0] rcon;
  logic [31:0] prev, rot, sub, temp, word;
  logic accept;
  assign prev = win[31:0];
  assign rot = j == 3'd0 ? {prev[23:0], prev[31:24]} : prev;
  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes_sbox u_sbox (.a(rot[8*b +: 8]), .q(sub[8*b +: 8]));
  end
  assign temp = j == 3'd0 ? sub ^ {rcon, 24'h0} : (NK == 8 && j == 3'd4) ? sub : prev;
  assign word = win[KEY_BITS-1 -: 32] ^ (i < NKW ? 32'h0 : temp);
  assign accept = state == HOLD && rk_ready;
  assign busy = state == GEN || state == HOLD;
  assign rk_valid = state == HOLD;
  assign done = state == FIN;
  always_comb
    nxt = state == IDLE ? (start ? GEN : IDLE) :
          state == GEN  ? (i[1:0] == 2'd3 ? HOLD : GEN) :
          state == HOLD ? (rk_ready ? (i == LAST ? FIN : GEN) : HOLD) : IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      win <= '0;
      part <= '0;
      i <= '0;
      j <= '0;
      rcon <= 8'h01;
      rk_index <= '0;
      rk_data <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        win <= key_in;
        i <= '0;
        j <= '0;
        rcon <= 8'h01;
      end
      if (state == GEN) begin
        win <= {win[KEY_BITS-33:0], word};
        part <= {part[63:0], word};
        j <= j == NKJ ? 3'd0 : j + 3'd1;
        if (i >= NKW && j == 3'd0) rcon <= xtime(rcon);
        if (i[1:0] == 2'd3) begin
          rk_data <= {part, word};
          rk_index <= i[5:2];
        end else i <= i + 6'd1;
      end
      if (accept && i != LAST) i <= i + 6'd1;
    end
`ifdef AES_KS_CACHE_EN
  localparam logic [3:0] NRI = 4'(NR);
  logic [AES_BLOCK-1:0] cache [16];
  always_ff @(posedge clk)
    if (accept) cache[rk_index] <= rk_data;
  always_ff @(posedge clk)
    if (rst) begin
      cache_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      cache_valid <= state == FIN ? 1'b1 : (state == IDLE && start) ? 1'b0 : cache_valid;
      rd_data <= rd_idx > NRI ? '0 : cache[rd_idx];
    end
`endif
endmodule
